// File: rtl/scoreboard.sv
// ============================================================================
// Module   : scoreboard (with ariane_pkg types)
// Purpose  : In-order issue/commit scoreboard with writeback and operand forwarding
// Revision : 1.0
// ============================================================================
`default_nettype none

package ariane_pkg;
    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception                 ex;
    } scoreboard_entry;
endpackage

module scoreboard #(
    parameter int NR_ENTRIES  = 8,
    parameter int NR_WB_PORTS = 3,
    localparam int IDW        = $clog2(NR_ENTRIES)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    output logic                                        full_o,
    input  ariane_pkg::scoreboard_entry                 decoded_instr_i,
    input  logic                                        decoded_instr_valid_i,
    output logic                                        decoded_instr_ack_o,
    output logic [IDW-1:0]                              issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDW-1:0]             wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                wb_data_i,
    input  ariane_pkg::exception [NR_WB_PORTS-1:0]      wb_ex_i,
    output ariane_pkg::scoreboard_entry                 commit_instr_o,
    output logic                                        commit_valid_o,
    input  logic                                        commit_ack_i,
    input  logic [4:0]                                  rs1_i,
    input  logic [4:0]                                  rs2_i,
    output logic                                        rs1_busy_o,
    output logic                                        rs2_busy_o,
    output logic                                        rs1_valid_o,
    output logic                                        rs2_valid_o,
    output logic [63:0]                                 rs1_o,
    output logic [63:0]                                 rs2_o
);

    ariane_pkg::scoreboard_entry mem_q [NR_ENTRIES];
    ariane_pkg::scoreboard_entry mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] busy_q, busy_d;
    logic [IDW-1:0]        head_q, head_d;
    logic [IDW-1:0]        tail_q, tail_d;
    logic [IDW:0]          cnt_q, cnt_d;
    logic                  issue_fire;
    logic                  commit_fire;

    assign full_o              = (cnt_q == (IDW+1)'(NR_ENTRIES));
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o    = tail_q;
    assign commit_instr_o      = mem_q[head_q];
    assign commit_valid_o      = busy_q[head_q] & (mem_q[head_q].valid | mem_q[head_q].ex.valid);
    assign issue_fire          = decoded_instr_ack_o;
    assign commit_fire         = commit_valid_o & commit_ack_i & ~flush_i;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            busy_d = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins a collision
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && busy_q[wb_trans_id_i[p]] &&
                    !(commit_fire && (wb_trans_id_i[p] == head_q))) begin
                    mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
                    mem_d[wb_trans_id_i[p]].valid  = 1'b1;
                    if (wb_ex_i[p].valid) begin
                        mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
                    end
                end
            end
            if (commit_fire) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + IDW'(1);
            end
            if (issue_fire) begin
                mem_d[tail_q]          = decoded_instr_i;
                mem_d[tail_q].trans_id = ariane_pkg::TRANS_ID_BITS'(tail_q);
                mem_d[tail_q].valid    = 1'b0;
                busy_d[tail_q]         = 1'b1;
                tail_d                 = tail_q + IDW'(1);
            end
            case ({issue_fire, commit_fire})
                2'b10:   cnt_d = cnt_q + (IDW+1)'(1);
                2'b01:   cnt_d = cnt_q - (IDW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last hit is the youngest in-flight writer
    always_comb begin
        logic [IDW-1:0] idx;
        idx         = '0;
        rs1_busy_o  = 1'b0;
        rs1_valid_o = 1'b0;
        rs1_o       = '0;
        rs2_busy_o  = 1'b0;
        rs2_valid_o = 1'b0;
        rs2_o       = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            idx = head_q + IDW'(k);
            if (busy_q[idx] && (rs1_i != 5'd0) && (mem_q[idx].rd == rs1_i)) begin
                rs1_busy_o  = ~mem_q[idx].valid;
                rs1_valid_o = mem_q[idx].valid;
                rs1_o       = mem_q[idx].valid ? mem_q[idx].result : 64'd0;
            end
            if (busy_q[idx] && (rs2_i != 5'd0) && (mem_q[idx].rd == rs2_i)) begin
                rs2_busy_o  = ~mem_q[idx].valid;
                rs2_valid_o = mem_q[idx].valid;
                rs2_o       = mem_q[idx].valid ? mem_q[idx].result : 64'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scoreboard.sv
// ============================================================================
// Module   : tb_scoreboard
// Purpose  : Randomised + directed bench with queue reference model and commit monitor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scoreboard;
    localparam int NR  = 8;
    localparam int NWB = 3;

    logic                               clk = 1'b0;
    logic                               rst_ni = 1'b0;
    logic                               flush_i = 1'b0;
    logic                               full_o;
    ariane_pkg::scoreboard_entry        decoded_instr_i = '0;
    logic                               decoded_instr_valid_i = 1'b0;
    logic                               decoded_instr_ack_o;
    logic [2:0]                         issue_trans_id_o;
    logic [NWB-1:0]                     wb_valid_i = '0;
    logic [NWB-1:0][2:0]                wb_trans_id_i = '0;
    logic [NWB-1:0][63:0]               wb_data_i = '0;
    ariane_pkg::exception [NWB-1:0]     wb_ex_i = '0;
    ariane_pkg::scoreboard_entry        commit_instr_o;
    logic                               commit_valid_o;
    logic                               commit_ack_i = 1'b0;
    logic [4:0]                         rs1_i = '0, rs2_i = '0;
    logic                               rs1_busy_o, rs2_busy_o, rs1_valid_o, rs2_valid_o;
    logic [63:0]                        rs1_o, rs2_o;

    scoreboard #(.NR_ENTRIES(NR), .NR_WB_PORTS(NWB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .full_o(full_o),
        .decoded_instr_i(decoded_instr_i), .decoded_instr_valid_i(decoded_instr_valid_i),
        .decoded_instr_ack_o(decoded_instr_ack_o), .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i),
        .wb_ex_i(wb_ex_i), .commit_instr_o(commit_instr_o), .commit_valid_o(commit_valid_o),
        .commit_ack_i(commit_ack_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] result;
        bit          valid;
        bit          exv;
        logic [63:0] cause;
    } m_t;

    m_t mq[$];     // in-flight instructions, oldest first
    m_t exp_q[$];  // expected retirements
    int next_id = 0;
    int n_chk = 0;
    int n_fail = 0;

    // stimulus for the next cycle
    bit          s_rst_n, s_flush, s_dv, s_ack, s_exv, s_wbexv;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [63:0] s_pc, s_res, s_cause, s_wbcause;
    bit   [NWB-1:0]   s_wbv;
    logic [2:0]       s_wbid   [NWB];
    logic [63:0]      s_wbdata [NWB];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        s_rst_n = 1; s_flush = 0; s_dv = 0; s_ack = 0; s_exv = 0; s_wbexv = 0;
        s_rd = 0; s_rs1 = 0; s_rs2 = 0; s_pc = 0; s_res = 0; s_cause = 0; s_wbcause = 0;
        s_wbv = '0;
        for (int p = 0; p < NWB; p++) begin
            s_wbid[p] = 0; s_wbdata[p] = 0;
        end
    endtask

    task automatic chk_lookup(input string nm, input logic [4:0] rs, input logic b,
                              input logic v, input logic [63:0] d);
        bit eb, ev;
        logic [63:0] ed;
        eb = 0; ev = 0; ed = 0;
        if (rs != 0) begin
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (mq[j].rd == rs) begin
                    ev = mq[j].valid;
                    eb = !mq[j].valid;
                    ed = ev ? mq[j].result : 64'd0;
                    break;
                end
            end
        end
        chk({nm, "_busy"}, {63'd0, b}, {63'd0, eb});
        chk({nm, "_valid"}, {63'd0, v}, {63'd0, ev});
        chk({nm, "_data"}, d, ed);
    endtask

    // One clock cycle: drive stimulus, check outputs against model, advance model
    task automatic step();
        ariane_pkg::scoreboard_entry di;
        bit full_m, ack_m, cv_m, com;
        m_t n;
        @(posedge clk);
        #2;
        di = '0;
        di.pc = s_pc; di.rd = s_rd; di.result = s_res;
        di.trans_id = 3'($urandom);
        di.ex.valid = s_exv; di.ex.cause = s_cause;
        rst_ni = s_rst_n; flush_i = s_flush;
        decoded_instr_i = di; decoded_instr_valid_i = s_dv;
        commit_ack_i = s_ack; rs1_i = s_rs1; rs2_i = s_rs2;
        for (int p = 0; p < NWB; p++) begin
            wb_valid_i[p] = s_wbv[p];
            wb_trans_id_i[p] = s_wbid[p];
            wb_data_i[p] = s_wbdata[p];
            wb_ex_i[p] = '0;
            wb_ex_i[p].valid = s_wbexv;
            wb_ex_i[p].cause = s_wbcause;
        end
        #1;
        full_m = (mq.size() == NR);
        ack_m  = s_dv && !full_m && !s_flush;
        cv_m   = (mq.size() > 0) && (mq[0].valid || mq[0].exv);
        chk("full", {63'd0, full_o}, {63'd0, full_m});
        chk("ack", {63'd0, decoded_instr_ack_o}, {63'd0, ack_m});
        chk("issue_id", {61'd0, issue_trans_id_o}, 64'(next_id));
        chk("commit_valid", {63'd0, commit_valid_o}, {63'd0, cv_m});
        chk_lookup("rs1", s_rs1, rs1_busy_o, rs1_valid_o, rs1_o);
        chk_lookup("rs2", s_rs2, rs2_busy_o, rs2_valid_o, rs2_o);

        if (!s_rst_n || s_flush) begin
            mq.delete();
            next_id = 0;
        end else begin
            com = cv_m && s_ack;
            for (int p = 0; p < NWB; p++) begin
                if (s_wbv[p]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].id == int'(s_wbid[p]) && !(com && j == 0)) begin
                            mq[j].result = s_wbdata[p];
                            mq[j].valid  = 1;
                            if (s_wbexv) begin
                                mq[j].exv = 1;
                                mq[j].cause = s_wbcause;
                            end
                        end
                    end
                end
            end
            if (com) begin
                exp_q.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (ack_m) begin
                n.id = next_id; n.rd = s_rd; n.pc = s_pc; n.result = s_res;
                n.valid = 0; n.exv = s_exv; n.cause = s_cause;
                mq.push_back(n);
                next_id = (next_id + 1) % NR;
            end
        end
    endtask

    // Monitor: compare every retirement against the oldest expected one
    initial begin
        m_t e;
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && flush_i === 1'b0 &&
                commit_valid_o === 1'b1 && commit_ack_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("c_trans_id", {61'd0, commit_instr_o.trans_id}, 64'(e.id));
                    chk("c_rd", {59'd0, commit_instr_o.rd}, {59'd0, e.rd});
                    chk("c_pc", commit_instr_o.pc, e.pc);
                    chk("c_result", commit_instr_o.result, e.result);
                    chk("c_valid", {63'd0, commit_instr_o.valid}, {63'd0, e.valid});
                    chk("c_exv", {63'd0, commit_instr_o.ex.valid}, {63'd0, e.exv});
                    chk("c_cause", commit_instr_o.ex.cause, e.cause);
                end
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;

        // Post-reset state
        idle(); s_rs1 = 5'd3; step();
        chk("rst_full", {63'd0, full_o}, 64'd0);
        chk("rst_cv", {63'd0, commit_valid_o}, 64'd0);
        chk("rst_id", {61'd0, issue_trans_id_o}, 64'd0);

        // Fill: IDs 0..7, then refuse the ninth
        for (int i = 0; i < NR; i++) begin
            idle(); s_dv = 1; s_rd = 5'(i + 1); s_pc = 64'(i * 4); step();
            chk("fill_id", {61'd0, issue_trans_id_o}, 64'(i));
        end
        idle(); s_dv = 1; s_rd = 5'd9; step();
        chk("full_ack", {63'd0, decoded_instr_ack_o}, 64'd0);
        chk("full_flag", {63'd0, full_o}, 64'd1);
        chk("full_cv", {63'd0, commit_valid_o}, 64'd0);

        // Writeback ID0, then commit while issuing: issue refused, then wraps to ID0
        idle(); s_wbv[0] = 1; s_wbid[0] = 0; s_wbdata[0] = 64'hAA; step();
        idle(); s_ack = 1; s_dv = 1; s_rd = 5'd20; step();
        chk("wrap_ack_blocked", {63'd0, decoded_instr_ack_o}, 64'd0);
        chk("wrap_result", commit_instr_o.result, 64'hAA);
        idle(); s_dv = 1; s_rd = 5'd20; step();
        chk("wrap_ack", {63'd0, decoded_instr_ack_o}, 64'd1);
        chk("wrap_id", {61'd0, issue_trans_id_o}, 64'd0);

        // Youngest-writer forwarding
        idle(); s_flush = 1; step();
        idle(); s_dv = 1; s_rd = 5'd9; step();
        idle(); s_dv = 1; s_rd = 5'd5; step();
        idle(); s_dv = 1; s_rd = 5'd5; step();
        idle(); s_wbv[0] = 1; s_wbid[0] = 1; s_wbdata[0] = 64'h33; step();
        idle(); s_rs1 = 5'd5; step();
        chk("fwd_busy", {63'd0, rs1_busy_o}, 64'd1);
        idle(); s_wbv[1] = 1; s_wbid[1] = 2; s_wbdata[1] = 64'h55; step();
        idle(); s_rs1 = 5'd5; step();
        chk("fwd_valid", {63'd0, rs1_valid_o}, 64'd1);
        chk("fwd_data", rs1_o, 64'h55);

        // Same-ID collision and writeback to a free slot
        idle(); s_dv = 1; s_rd = 5'd7; step();
        idle();
        s_wbv = 3'b111;
        s_wbid[0] = 3; s_wbdata[0] = 64'h11;
        s_wbid[1] = 6; s_wbdata[1] = 64'h99;
        s_wbid[2] = 3; s_wbdata[2] = 64'h22;
        step();
        idle(); s_rs2 = 5'd7; step();
        chk("coll_data", rs2_o, 64'h22);

        // Flush beats same-cycle issue and commit
        idle(); s_wbv[0] = 1; s_wbid[0] = 0; s_wbdata[0] = 64'h77; step();
        idle(); s_flush = 1; s_dv = 1; s_ack = 1; s_rd = 5'd4; step();
        chk("flush_ack", {63'd0, decoded_instr_ack_o}, 64'd0);
        idle(); s_rs1 = 5'd5; s_rs2 = 5'd9; step();
        chk("flush_id", {61'd0, issue_trans_id_o}, 64'd0);
        chk("flush_rs1", {63'd0, rs1_busy_o}, 64'd0);

        // Reset mid-stream, then exception writeback on head
        for (int i = 0; i < 3; i++) begin
            idle(); s_dv = 1; s_rd = 5'(i + 1); step();
        end
        idle(); s_rst_n = 0; step();
        idle(); s_rs1 = 5'd2; step();
        chk("mrst_id", {61'd0, issue_trans_id_o}, 64'd0);
        chk("mrst_cv", {63'd0, commit_valid_o}, 64'd0);
        idle(); s_dv = 1; s_rd = 5'd3; s_pc = 64'h100; step();
        idle(); s_wbv[1] = 1; s_wbid[1] = 0; s_wbdata[1] = 64'h1; s_wbexv = 1; s_wbcause = 64'h5; step();
        idle(); step();
        chk("ex_cv", {63'd0, commit_valid_o}, 64'd1);
        chk("ex_cause", commit_instr_o.ex.cause, 64'h5);
        idle(); s_ack = 1; step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            s_rst_n = ($urandom_range(0, 299) != 0);
            s_flush = ($urandom_range(0, 79) == 0);
            s_dv    = ($urandom_range(0, 9) < 7);
            s_ack   = ($urandom_range(0, 9) < 6);
            s_rd    = 5'($urandom_range(0, 7));
            s_pc    = {32'd0, $urandom};
            s_res   = {32'd0, $urandom};
            s_exv   = ($urandom_range(0, 31) == 0);
            s_cause = 64'($urandom_range(0, 15));
            s_rs1   = 5'($urandom_range(0, 7));
            s_rs2   = 5'($urandom_range(0, 7));
            s_wbexv = ($urandom_range(0, 7) == 0);
            s_wbcause = 64'($urandom_range(0, 15));
            for (int p = 0; p < NWB; p++) begin
                s_wbv[p] = ($urandom_range(0, 9) < 4);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    s_wbid[p] = 3'(mq[$urandom_range(0, mq.size() - 1)].id);
                else
                    s_wbid[p] = 3'($urandom_range(0, 7));
                s_wbdata[p] = {$urandom, $urandom};
            end
            step();
        end

        idle(); step();
        chk("pending_commits", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8: entry count; power of two, >=2; IDW = $clog2(NR_ENTRIES).
REQ-002 SHALL have parameter NR_WB_PORTS, default 3: number of writeback ports, >=1.
REQ-003 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  discard all in-flight entries.
REQ-006 SHALL have port full_o  out  1  count == NR_ENTRIES.
REQ-007 SHALL have port decoded_instr_i  in  ariane_pkg::scoreboard_entry  instruction to enter.
REQ-008 SHALL have port decoded_instr_valid_i  in  1  decoded_instr_i valid.
REQ-009 SHALL have port decoded_instr_ack_o  out  1  instruction accepted this cycle.
REQ-010 SHALL have port issue_trans_id_o  out  IDW  ID given to the instruction accepted this cycle.
REQ-011 SHALL have port wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe.
REQ-012 SHALL have port wb_trans_id_i  in  NR_WB_PORTS x IDW  target entry per port.
REQ-013 SHALL have port wb_data_i  in  NR_WB_PORTS x 64  result per port.
REQ-014 SHALL have port wb_ex_i  in  NR_WB_PORTS x ariane_pkg::exception  exception per port.
REQ-015 SHALL have port commit_instr_o  out  scoreboard_entry  oldest entry.
REQ-016 SHALL have port commit_valid_o  out  1  oldest entry ready to retire.
REQ-017 SHALL have port commit_ack_i  in  1  retire oldest entry.
REQ-018 SHALL have port rs1_i, rs2_i  in  5 each  source registers to look up.
REQ-019 SHALL have port rs1_busy_o, rs2_busy_o  out  1 each  youngest writer in flight, result pending.
REQ-020 SHALL have port rs1_valid_o, rs2_valid_o  out  1 each  youngest writer's result forwardable.
REQ-021 SHALL have port rs1_o, rs2_o  out  64 each  forwarded result.

Function
REQ-022 SHALL hold NR_ENTRIES scoreboard_entry slots plus per-slot busy bit; head, tail pointers IDW bits, wrap modulo NR_ENTRIES; count IDW+1 bits.
REQ-023 SHALL drive decoded_instr_ack_o = decoded_instr_valid_i & !full_o & !flush_i; no combinational dependence on commit_ack_i (full blocks issue even if commit retires same cycle).
REQ-024 On accept SHALL write slot[tail] from decoded_instr_i, set busy, clear valid, overwrite trans_id field with tail (zero-extended/truncated to TRANS_ID_BITS), advance tail; issue_trans_id_o = tail combinationally.
REQ-025 For each wb port with wb_valid_i set and target slot busy SHALL next cycle set result=wb_data_i, valid=1; ex replaced by wb_ex_i only when wb_ex_i.valid, else decode-time ex kept.
REQ-026 Writeback to non-busy slot SHALL be ignored; two ports hitting same ID same cycle: highest port index wins.
REQ-027 SHALL drive commit_valid_o = busy[head] & (valid[head] | ex.valid[head]); commit_instr_o = slot[head] always.
REQ-028 On commit_valid_o & commit_ack_i SHALL clear busy[head], advance head; commit_ack_i without commit_valid_o ignored.
REQ-029 Writeback to the slot retiring same cycle SHALL be ignored; issue+commit same cycle leaves count unchanged.
REQ-030 Lookup for rsX SHALL scan busy slots youngest-to-oldest for rd == rsX; rsX == 0 never matches.
REQ-031 Youngest match with valid: rsX_valid_o=1, rsX_o=result, rsX_busy_o=0; match without valid: busy=1, valid=0; no match: both 0, rsX_o=0.
REQ-032 Writebacks and issues in the current cycle SHALL become visible to lookup only from the next cycle.
REQ-033 flush_i SHALL, next cycle, clear all busy bits, head=tail=count=0; same-cycle issue, writeback, commit ignored.
REQ-034 All outputs SHALL be combinational from registered state plus decoded_instr_valid_i, flush_i and rsX_i only.

Reset
REQ-035 rst_ni low at a clock edge SHALL clear all slots to zero, busy=0, head=tail=count=0; while empty: full_o=0, commit_valid_o=0, all rsX_busy_o/rsX_valid_o=0, issue_trans_id_o=0.
REQ-036 Reset mid-operation SHALL discard in-flight entries identically to flush; reset dominates flush_i.

Verification
REQ-037 Issue 8 instrs (rd=1..8), no wb -> IDs 0..7, full_o=1 after 8th, 9th not acked, commit_valid_o=0.
REQ-038 Full, wb ID0 data 0xAA, commit ack while issuing -> ID0 retired with result 0xAA, issue refused that cycle, accepted next cycle with ID 0 (wrap).
REQ-039 Two in-flight rd=5 (IDs 1,2), wb ID1 only, rs1_i=5 -> rs1_busy_o=1; after wb ID2 data 0x55 -> rs1_valid_o=1, rs1_o=0x55.
REQ-040 Ports 0 and 2 write ID3 same cycle (0x11, 0x22) -> slot 3 result 0x22; wb to free ID6 -> no change.
REQ-041 4 busy, flush_i with valid issue and commit ack -> neither acked, next cycle count=0, tail=0, lookups clear.
REQ-042 rst_ni low mid-stream with flush_i=0 -> next cycle state as REQ-035; wb ex.valid cause 0x5 on head -> commit_valid_o=1 with ex.cause=0x5.
